// File: rtl/button_event_ctrl.sv
// Button event controller: turns a debounced button level into SHORT, LONG and
// REPEAT events and delivers them over a valid/ready handshake with overflow tracking.
module button_event_ctrl #(
  parameter int LONG_CNT   = 1000000,
  parameter int REPEAT_CNT = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_level,
  input  logic       enable,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ready,
  output logic       evt_overflow
);

  localparam int MAX_CNT = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CNT - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CNT - 1);

  localparam logic [1:0] CODE_NONE   = 2'b00;
  localparam logic [1:0] CODE_SHORT  = 2'b01;
  localparam logic [1:0] CODE_LONG   = 2'b10;
  localparam logic [1:0] CODE_REPEAT = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          emit;
  logic [1:0]    emit_code;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Disabling wins over everything: it drops any hold in progress without an event.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    emit       = 1'b0;
    emit_code  = CODE_NONE;
    if (!enable) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (btn_level) begin
            state_next = HELD;
            cnt_next   = '0;
          end
        end
        HELD: begin
          if (!btn_level) begin
            state_next = IDLE;
            emit       = 1'b1;
            emit_code  = CODE_SHORT;
          end else if (cnt == LONG_LAST) begin
            state_next = REPEAT;
            cnt_next   = '0;
            emit       = 1'b1;
            emit_code  = CODE_LONG;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        REPEAT: begin
          if (!btn_level) begin
            state_next = IDLE;
          end else if (cnt == REPEAT_LAST) begin
            cnt_next  = '0;
            emit      = 1'b1;
            emit_code = CODE_REPEAT;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // A new event may take the slot if it is empty or being drained this edge;
  // otherwise the pending event is kept and the new one is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_valid    <= 1'b0;
      evt_code     <= CODE_NONE;
      evt_overflow <= 1'b0;
    end else begin
      if (emit && evt_valid && !evt_ready) begin
        evt_overflow <= 1'b1;
      end else if (emit) begin
        evt_valid <= 1'b1;
        evt_code  <= emit_code;
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
        evt_code  <= CODE_NONE;
      end
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl with LONG_CNT=8, REPEAT_CNT=4; every
// handshake transfer is matched against a queue of expected event codes.
module tb_button_event_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_level;
  logic       enable;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready;
  logic       evt_overflow;

  int tests = 0;
  int fails = 0;

  logic [1:0] exp_q[$];

  localparam logic [1:0] SHORT  = 2'b01;
  localparam logic [1:0] LONG   = 2'b10;
  localparam logic [1:0] REPEAT = 2'b11;

  button_event_ctrl #(.LONG_CNT(8), .REPEAT_CNT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_level    (btn_level),
    .enable       (enable),
    .evt_valid    (evt_valid),
    .evt_code     (evt_code),
    .evt_ready    (evt_ready),
    .evt_overflow (evt_overflow)
  );

  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [1:0] c, input logic o);
    check({tag, ".valid"}, {1'b0, evt_valid}, {1'b0, v});
    check({tag, ".code"}, evt_code, c);
    check({tag, ".ovf"}, {1'b0, evt_overflow}, {1'b0, o});
  endtask

  // Scoreboard: a transfer is sampled mid-cycle ahead of the edge that performs it.
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_event: observed code %b expected no event", evt_code);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        check("transfer", evt_code, e);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    btn_level = 1'b0;
    enable    = 1'b1;
    evt_ready = 1'b1;
    #3;
    check_out("reset", 1'b0, 2'b00, 1'b0);
    cycles(2);
    reset = 1'b0;
    cycles(2);

    // Short press of three cycles
    btn_level = 1'b1;
    exp_q.push_back(SHORT);
    cycles(3);
    btn_level = 1'b0;
    cycles(1);
    check_out("short", 1'b1, SHORT, 1'b0);
    cycles(1);
    check_out("short_done", 1'b0, 2'b00, 1'b0);
    cycles(3);

    // Twenty-cycle hold: LONG at +8, REPEAT at +12 and +16, nothing on release
    btn_level = 1'b1;
    exp_q.push_back(LONG);
    exp_q.push_back(REPEAT);
    exp_q.push_back(REPEAT);
    cycles(8);
    check_out("long_early", 1'b0, 2'b00, 1'b0);
    cycles(1);
    check_out("long", 1'b1, LONG, 1'b0);
    cycles(3);
    check_out("rep1_early", 1'b0, 2'b00, 1'b0);
    cycles(1);
    check_out("rep1", 1'b1, REPEAT, 1'b0);
    cycles(4);
    check_out("rep2", 1'b1, REPEAT, 1'b0);
    cycles(3);
    btn_level = 1'b0;
    cycles(4);
    check_out("release_quiet", 1'b0, 2'b00, 1'b0);

    // Consumer stalled: LONG held, REPEAT dropped with overflow
    evt_ready = 1'b0;
    btn_level = 1'b1;
    exp_q.push_back(LONG);
    cycles(9);
    check_out("stall_long", 1'b1, LONG, 1'b0);
    cycles(4);
    check_out("stall_ovf", 1'b1, LONG, 1'b1);
    cycles(7);
    btn_level = 1'b0;
    cycles(2);
    check_out("stall_hold", 1'b1, LONG, 1'b1);
    evt_ready = 1'b1;
    cycles(1);
    check_out("stall_drain", 1'b0, 2'b00, 1'b1);
    cycles(2);
    reset = 1'b1;
    #1;
    check_out("ovf_reset", 1'b0, 2'b00, 1'b0);
    cycles(1);
    reset = 1'b0;
    cycles(2);

    // Pending SHORT drained at the same edge a LONG is emitted
    evt_ready = 1'b0;
    btn_level = 1'b1;
    exp_q.push_back(SHORT);
    exp_q.push_back(LONG);
    cycles(1);
    btn_level = 1'b0;
    cycles(1);
    check_out("pend_short", 1'b1, SHORT, 1'b0);
    btn_level = 1'b1;
    cycles(8);
    check_out("pend_wait", 1'b1, SHORT, 1'b0);
    evt_ready = 1'b1;
    cycles(1);
    check_out("swap_long", 1'b1, LONG, 1'b0);
    btn_level = 1'b0;
    cycles(3);
    check_out("swap_done", 1'b0, 2'b00, 1'b0);

    // Asynchronous reset mid-REPEAT with an event pending
    evt_ready = 1'b0;
    btn_level = 1'b1;
    cycles(10);
    check_out("pre_reset", 1'b1, LONG, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_out("async_reset", 1'b0, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    evt_ready = 1'b1;
    exp_q.push_back(LONG);
    cycles(8);
    check_out("post_reset_early", 1'b0, 2'b00, 1'b0);
    cycles(1);
    check_out("post_reset_long", 1'b1, LONG, 1'b0);
    btn_level = 1'b0;
    cycles(3);

    // Enable dropped on hold cycle 5, restored while still held
    btn_level = 1'b1;
    exp_q.push_back(LONG);
    cycles(5);
    enable = 1'b0;
    cycles(1);
    enable = 1'b1;
    cycles(3);
    check_out("en_no_long", 1'b0, 2'b00, 1'b0);
    cycles(5);
    check_out("en_early", 1'b0, 2'b00, 1'b0);
    cycles(1);
    check_out("en_long", 1'b1, LONG, 1'b0);
    btn_level = 1'b0;
    cycles(4);

    check("queue_empty", 2'(exp_q.size()), 2'b00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
